playback_rate_gen: RTL and testbench
====================================

// Module: playback_rate_gen
// PURPOSE
//  Parametrised sample-rate enable generator for the audio record/playback path.
//  Replaces gated divided clocks with a single-cycle tick strobe in the CLK50 domain.
//  Each tick carries a sample-index step (normal / fast / slow) and, in slow mode, an interpolation phase.
//  The SRAM address sequencer and the interpolator consume these outputs directly.
// PARAMETERS
//  BASE_DIV  4  CLK50 cycles per base tick (>=1)
//  RATIO_W   3  width of ratio_m1; speed ratio range 1..2^RATIO_W
// PORTS
//  CLK50     in   1          system clock; all logic on posedge
//  RST_N     in   1          asynchronous active-low reset
//  mode      in   2          00 normal, 01 fast, 10 slow (repeat), 11 slow interpolated
//  ratio_m1  in   RATIO_W    speed ratio minus 1 (R)
//  pause     in   1          1 = suppress ticks, freeze phase
//  is_record in   1          1 = force normal mode (overrides mode)
//  tick_o    out  1          one-cycle strobe per active base tick
//  step_o    out  RATIO_W+1  sample-index increment for this tick (valid with tick_o)
//  phase_o   out  RATIO_W    interpolation numerator (valid with tick_o)
//  den_o     out  RATIO_W+1  interpolation denominator = active R+1
//  interp_o  out  1          1 = active mode is slow interpolated
// BEHAVIOUR
//  Reset: all regs 0 immediately; tick_o=0, step_o=0, phase_o=0, den_o=0, interp_o=0;
//   active cfg = normal, R=0. Reset mid-period discards phase; restart at div_cnt=0.
//  Base divider: div_cnt counts 0..BASE_DIV-1, wraps; runs during pause.
//   base_tick = (div_cnt==BASE_DIV-1). BASE_DIV=1 -> base_tick every cycle.
//  Latency: tick_o high exactly the cycle after base_tick, if pause=0 in the base_tick cycle.
//   Pause sampled in base_tick cycle wins; tick lost, not deferred. Outputs registered.
//  Effective mode: is_record=1 -> normal, else mode input.
//  Config latch (act_mode, act_R) loads from inputs on an unpaused base_tick when
//   phase_cnt==0 (period start); otherwise held. Non-slow active modes keep phase_cnt=0,
//   so they re-latch every tick. Mode or ratio changes inside a slow period take effect
//   at next period start. Latched value is used for that same tick.
//  Per unpaused base_tick, using latched cfg:
//   NORMAL: step_o=1, phase_o=0, phase_cnt stays 0.
//   FAST:   step_o=R+1 (1..2^RATIO_W, no overflow: width RATIO_W+1), phase_o=0.
//   SLOW/SLOW_INTERP: phase_o=phase_cnt; if phase_cnt==R: step_o=1, phase_cnt->0,
//    else step_o=0, phase_cnt+1. R=0 behaves as normal (step 1 every tick).
//  den_o = act_R+1 updated with each tick; interp_o = (act_mode==11); held between ticks.
//  step_o/phase_o hold last values while tick_o=0; consumers qualify with tick_o.
//  Pause: phase_cnt and cfg frozen; resume continues same period at next phase.
//  Simultaneous pause release and base_tick: tick issued (pause sampled low).
// TESTING
//  1 Normal, BASE_DIV=4, mode=00: tick_o every 4th cycle, 1 cycle wide, step_o=1, phase_o=0.
//  2 Fast, mode=01, ratio_m1=2: step_o=3 each tick; ratio_m1=7 -> step_o=8 (no wrap).
//  3 Slow interp, mode=11, R=2: ticks give phase_o 0,1,2,0..; step_o 0,0,1; den_o=3, interp_o=1.
//  4 R changed 3->1 at phase 1: phases 2,3 (step 1 at 3) complete, then 0,1 under R=1, den_o=2.
//  5 Pause asserted after phase 1 (R=3) for 20 cycles: no tick_o; on release next tick phase_o=2.
//  6 is_record=1 with mode=11: step_o=1, interp_o=0; RST_N low mid-period -> all outputs 0 at once.

Source files
------------

// File: rtl/playback_rate_gen_if.sv
// Control/status bundle between the playback rate generator and its consumers.
// The slave modport is the generator; the master modport is the controller/consumer side.
interface playback_rate_gen_if #(
    parameter int unsigned RATIO_W = 3
);
    logic [1:0]         mode;
    logic [RATIO_W-1:0] ratio_m1;
    logic               pause;
    logic               is_record;
    logic               tick_o;
    logic [RATIO_W:0]   step_o;
    logic [RATIO_W-1:0] phase_o;
    logic [RATIO_W:0]   den_o;
    logic               interp_o;

    modport master (
        output mode, ratio_m1, pause, is_record,
        input  tick_o, step_o, phase_o, den_o, interp_o
    );

    modport slave (
        input  mode, ratio_m1, pause, is_record,
        output tick_o, step_o, phase_o, den_o, interp_o
    );
endinterface

// File: rtl/playback_rate_gen.sv
// Sample-rate tick generator: single-cycle strobes in the CLK50 domain carrying a
// sample-index step and, in slow modes, an interpolation phase over a period of R+1 ticks.
module playback_rate_gen #(
    parameter int unsigned BASE_DIV = 4,
    parameter int unsigned RATIO_W  = 3
) (
    input  logic                 CLK50,
    input  logic                 RST_N,
    playback_rate_gen_if.slave   bus
);
    localparam int unsigned DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

    localparam logic [1:0] ModeNormal = 2'b00;
    localparam logic [1:0] ModeFast   = 2'b01;
    localparam logic [1:0] ModeInterp = 2'b11;

    logic [DIV_W-1:0]   r_div_cnt;
    logic [RATIO_W-1:0] r_phase_cnt;
    logic [1:0]         r_act_mode;
    logic [RATIO_W-1:0] r_act_r;
    logic               r_tick;
    logic [RATIO_W:0]   r_step;
    logic [RATIO_W-1:0] r_phase;
    logic [RATIO_W:0]   r_den;
    logic               r_interp;

    logic               w_base_tick;
    logic               w_fire;
    logic               w_period_start;
    logic [1:0]         w_eff_mode;
    logic [1:0]         w_cur_mode;
    logic [RATIO_W-1:0] w_cur_r;
    logic [RATIO_W:0]   w_cur_r_p1;

    assign w_base_tick    = (r_div_cnt == DIV_W'(BASE_DIV - 1));
    assign w_fire         = w_base_tick && !bus.pause;
    assign w_period_start = (r_phase_cnt == '0);
    assign w_eff_mode     = bus.is_record ? ModeNormal : bus.mode;
    // Config loaded at period start applies to that same tick.
    assign w_cur_mode     = w_period_start ? w_eff_mode : r_act_mode;
    assign w_cur_r        = w_period_start ? bus.ratio_m1 : r_act_r;
    assign w_cur_r_p1     = {1'b0, w_cur_r} + 1'b1;

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            r_div_cnt   <= '0;
            r_phase_cnt <= '0;
            r_act_mode  <= ModeNormal;
            r_act_r     <= '0;
            r_tick      <= 1'b0;
            r_step      <= '0;
            r_phase     <= '0;
            r_den       <= '0;
            r_interp    <= 1'b0;
        end else begin
            r_div_cnt <= w_base_tick ? '0 : r_div_cnt + 1'b1;
            r_tick    <= w_fire;
            if (w_fire) begin
                r_act_mode <= w_cur_mode;
                r_act_r    <= w_cur_r;
                r_den      <= w_cur_r_p1;
                r_interp   <= (w_cur_mode == ModeInterp);
                case (w_cur_mode)
                    ModeNormal: begin
                        r_step      <= RATIO_W'(1) + '0;
                        r_phase     <= '0;
                        r_phase_cnt <= '0;
                    end
                    ModeFast: begin
                        r_step      <= w_cur_r_p1;
                        r_phase     <= '0;
                        r_phase_cnt <= '0;
                    end
                    default: begin
                        r_phase <= r_phase_cnt;
                        if (r_phase_cnt == w_cur_r) begin
                            r_step      <= (RATIO_W + 1)'(1);
                            r_phase_cnt <= '0;
                        end else begin
                            r_step      <= '0;
                            r_phase_cnt <= r_phase_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.tick_o   = r_tick;
    assign bus.step_o   = r_step;
    assign bus.phase_o  = r_phase;
    assign bus.den_o    = r_den;
    assign bus.interp_o = r_interp;
endmodule

// File: tb/tb_playback_rate_gen.sv
// Self-checking bench: directed scenarios plus randomized control against a tick-level
// reference model of the slow/fast/normal period rules.
module tb_playback_rate_gen;
    localparam int unsigned BASE_DIV = 4;
    localparam int unsigned RATIO_W  = 3;

    logic clk;
    logic rst_n;

    playback_rate_gen_if #(.RATIO_W(RATIO_W)) u_if ();

    playback_rate_gen #(
        .BASE_DIV(BASE_DIV),
        .RATIO_W (RATIO_W)
    ) u_dut (
        .CLK50(clk),
        .RST_N(rst_n),
        .bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset, latched config, position in slow period.
    int m_cyc, m_mode, m_r, m_pos;
    int e_tick, e_step, e_phase, e_den, e_interp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cyc = 0; m_mode = 0; m_r = 0; m_pos = 0;
        e_tick = 0; e_step = 0; e_phase = 0; e_den = 0; e_interp = 0;
    endtask

    task automatic model_edge();
        m_cyc++;
        e_tick = 0;
        if ((m_cyc % BASE_DIV) == 0 && !u_if.pause) begin
            if (m_pos == 0) begin
                m_mode = u_if.is_record ? 0 : int'(u_if.mode);
                m_r    = int'(u_if.ratio_m1);
            end
            e_tick   = 1;
            e_den    = m_r + 1;
            e_interp = (m_mode == 3) ? 1 : 0;
            if (m_mode == 0) begin
                e_step = 1; e_phase = 0;
            end else if (m_mode == 1) begin
                e_step = m_r + 1; e_phase = 0;
            end else begin
                e_phase = m_pos;
                e_step  = (m_pos == m_r) ? 1 : 0;
                m_pos   = (m_pos + 1) % (m_r + 1);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick",   32'(u_if.tick_o),   e_tick);
        chk("step",   32'(u_if.step_o),   e_step);
        chk("phase",  32'(u_if.phase_o),  e_phase);
        chk("den",    32'(u_if.den_o),    e_den);
        chk("interp", 32'(u_if.interp_o), e_interp);
    endtask

    task automatic run_until_tick(input string tag);
        for (int i = 0; i < 8 * BASE_DIV; i++) begin
            step();
            if (e_tick == 1) break;
        end
        chk(tag, 32'(u_if.tick_o), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tick"},   32'(u_if.tick_o),   0);
        chk({tag, "_step"},   32'(u_if.step_o),   0);
        chk({tag, "_phase"},  32'(u_if.phase_o),  0);
        chk({tag, "_den"},    32'(u_if.den_o),    0);
        chk({tag, "_interp"}, 32'(u_if.interp_o), 0);
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        int ticks;
        int exp_ph[4];
        rst_n = 1'b1;
        u_if.mode = 2'b00; u_if.ratio_m1 = '0; u_if.pause = 1'b0; u_if.is_record = 1'b0;
        model_clear();
        #2;
        reset_pulse("reset");

        // Normal: one tick per BASE_DIV cycles, step 1, phase 0.
        ticks = 0;
        for (int i = 0; i < 3 * BASE_DIV; i++) begin
            step();
            ticks += int'(u_if.tick_o);
            if (u_if.tick_o) begin
                chk("normal_step", 32'(u_if.step_o), 1);
                chk("normal_phase", 32'(u_if.phase_o), 0);
            end
        end
        chk("normal_tick_count", ticks, 3);

        // Fast: step = R+1, widest ratio must not wrap.
        u_if.mode = 2'b01; u_if.ratio_m1 = 3'd2;
        run_until_tick("fast_r2_tick");
        chk("fast_r2_step", 32'(u_if.step_o), 3);
        u_if.ratio_m1 = 3'd7;
        run_until_tick("fast_r7_tick");
        chk("fast_r7_step", 32'(u_if.step_o), 8);

        // Slow interpolated, R=2.
        u_if.mode = 2'b11; u_if.ratio_m1 = 3'd2;
        for (int k = 0; k < 3; k++) begin
            run_until_tick("interp_tick");
            chk("interp_phase", 32'(u_if.phase_o), k);
            chk("interp_step", 32'(u_if.step_o), (k == 2) ? 1 : 0);
            chk("interp_den", 32'(u_if.den_o), 3);
            chk("interp_flag", 32'(u_if.interp_o), 1);
        end

        // Ratio change mid-period only takes effect at the next period start.
        u_if.ratio_m1 = 3'd3;
        run_until_tick("chg_t0");
        run_until_tick("chg_t1");
        chk("chg_phase1", 32'(u_if.phase_o), 1);
        u_if.ratio_m1 = 3'd1;
        exp_ph = '{2, 3, 0, 1};
        for (int k = 0; k < 4; k++) begin
            run_until_tick("chg_tick");
            chk("chg_phase", 32'(u_if.phase_o), exp_ph[k]);
            chk("chg_den", 32'(u_if.den_o), (k < 2) ? 4 : 2);
            chk("chg_step", 32'(u_if.step_o), (k == 1 || k == 3) ? 1 : 0);
        end

        // Pause after phase 1 freezes the period.
        u_if.ratio_m1 = 3'd3;
        run_until_tick("pause_t0");
        run_until_tick("pause_t1");
        u_if.pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("pause_no_tick", 32'(u_if.tick_o), 0);
        end
        u_if.pause = 1'b0;
        run_until_tick("resume_tick");
        chk("resume_phase", 32'(u_if.phase_o), 2);
        run_until_tick("resume_t3");

        // Record overrides mode.
        u_if.is_record = 1'b1;
        run_until_tick("rec_tick");
        chk("rec_step", 32'(u_if.step_o), 1);
        chk("rec_interp", 32'(u_if.interp_o), 0);
        u_if.is_record = 1'b0;

        // Reset in the middle of a slow period.
        run_until_tick("mid_t0");
        run_until_tick("mid_t1");
        step();
        reset_pulse("midreset");
        for (int i = 0; i < 2 * BASE_DIV; i++) step();

        // Randomized control.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) u_if.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) u_if.ratio_m1 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) u_if.pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) u_if.is_record = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
